program_sequencer_stack: RTL
============================

Name: program_sequencer_stack

Overview:
- Parametrised next-generation program sequencer for the small-CPU datapath. Generates the program-memory fetch address and holds the registered program counter.
- Adds a configurable PC width, a hardware call/return stack, a fetch hold (stall) and sticky stack error flags.
- Sits between the instruction decoder (jump/call/ret/hold controls) and program memory.

Parameters:
- PC_W, 8, width of pc, pm_addr and stack entries (4..16).
- JMP_W, 4, width of jmp_addr; must be <= PC_W. Jump target = {jmp_addr, (PC_W-JMP_W) zeros}.
- STACK_DEPTH, 4, number of return-address entries (1..16).
- SP_W, clog2(STACK_DEPTH+1), derived width of sp.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous restart, active-high
- hold  in  1  stall: refetch current pc, freeze all state
- jmp  in  1  unconditional jump
- jmp_nz  in  1  conditional jump, taken when dont_jmp=0
- dont_jmp  in  1  zero flag from ALU; suppresses jmp_nz
- call  in  1  jump and push return address
- ret  in  1  pop return address into pm_addr
- jmp_addr  in  JMP_W  jump/call target upper bits
- pm_addr  out  PC_W  combinational next fetch address
- pc  out  PC_W  registered program counter
- sp  out  SP_W  stack occupancy, 0..STACK_DEPTH
- stack_full  out  1  sp == STACK_DEPTH (combinational)
- stack_empty  out  1  sp == 0 (combinational)
- stack_overflow  out  1  sticky: call attempted while full
- stack_underflow  out  1  sticky: ret attempted while empty

Behaviour:
- Async reset (reset_n=0): pc=0, sp=0, all stack entries=0, both sticky flags=0. pm_addr forced to 0 while reset_n=0.
- Every rising clk edge with reset_n=1: pc <= pm_addr. Zero-cycle latency from controls to pm_addr; one cycle to pc.
- pm_addr priority, highest first:
  1. sync_reset: 0.
  2. hold: pc.
  3. jmp: target.
  4. call: target.
  5. ret: top-of-stack when sp>0, else pc+1.
  6. jmp_nz && !dont_jmp: target.
  7. Otherwise pc+1.
- Increment is modulo 2^PC_W: all-ones wraps to 0.
- sync_reset at the edge: sp<=0, flags<=0, stack contents don't-care. Lower-priority controls are ignored.
- hold at the edge: pc reloads the same value; sp, stack and flags unchanged; all other controls ignored.
- call taken (priority 4 reached):
  - sp<STACK_DEPTH: stack[sp] <= pc+1 (wrapped), sp<=sp+1.
  - sp==STACK_DEPTH: no push, sp unchanged, stack_overflow<=1. The jump is still taken.
- ret taken (priority 5 reached):
  - sp>0: pm_addr = stack[sp-1], sp<=sp-1.
  - sp==0: stack_underflow<=1, sequential fall-through.
- Simultaneous controls resolve by priority only:
  - jmp+call: jump, no push.
  - call+ret: push only.
  - ret+jmp_nz: pop only.
- Sticky flags clear only on reset_n=0 or sync_reset=1.
- reset_n assertion mid-call/ret aborts with no partial stack update.
- Stack storage is a register array; no memory macros.

Test Plan:
- Reset then free-run, PC_W=8: reset_n low (pm_addr=0), release -> pc 0,1,2,…; from pc=8'hFE -> pm_addr FF then 00, wrapping.
- jmp_addr=4'h3, jmp=1 at pc=8'h05 -> pm_addr=8'h30, next pc=8'h30. jmp_nz=1 with dont_jmp=1 -> pm_addr=pc+1. With dont_jmp=0 -> 8'h30.
- Nested calls, STACK_DEPTH=4: call 4'h1 at pc=02, 4'h2 at pc=11, 4'h3 at pc=21 -> sp=3. Three rets return pm_addr 22, 12, 03, ending with sp=0.
- Overflow/underflow: 5 consecutive calls with depth 4 -> stack_overflow=1 after 5th, sp=4, jump still taken. Ret with sp=0 -> stack_underflow=1, pm_addr=pc+1. Flags hold until sync_reset.
- Hold and priority: hold=1 with jmp=1 for 3 cycles -> pm_addr=pc, sp unchanged. Call+ret same cycle -> push only. jmp+call -> sp unchanged.
- sync_reset asserted with call=1 and sp=2 -> pm_addr=0, next pc=0, sp=0, flags 0. reset_n pulsed low mid-run -> pc=0 immediately (asynchronous).

Source files
------------

// File: rtl/program_sequencer_stack_if.sv
// rtl/program_sequencer_stack_if.sv - decoder-to-sequencer control and status bundle
interface program_sequencer_stack_if #(
  parameter int PC_W        = 8,
  parameter int JMP_W       = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
);
  logic              sync_reset;
  logic              hold;
  logic              jmp;
  logic              jmp_nz;
  logic              dont_jmp;
  logic              call;
  logic              ret;
  logic [JMP_W-1:0]  jmp_addr;
  logic [PC_W-1:0]   pm_addr;
  logic [PC_W-1:0]   pc;
  logic [SP_W-1:0]   sp;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_overflow;
  logic              stack_underflow;

  modport master (
    output sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    input  pm_addr, pc, sp, stack_full, stack_empty, stack_overflow, stack_underflow
  );

  modport slave (
    input  sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    output pm_addr, pc, sp, stack_full, stack_empty, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/program_sequencer_stack.sv
// rtl/program_sequencer_stack.sv - program counter with call/return stack and fetch hold
module program_sequencer_stack #(
  parameter int PC_W        = 8,
  parameter int JMP_W       = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  program_sequencer_stack_if.slave bus
);
  logic [PC_W-1:0] pc;
  logic [SP_W-1:0] sp;
  logic            ovf;
  logic            unf;
  logic [PC_W-1:0] stack_mem [STACK_DEPTH];

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] tos;
  logic [PC_W-1:0] pm_next;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            ovf_set;
  logic            unf_set;

  assign pc_inc = pc + PC_W'(1);
  assign target = PC_W'(bus.jmp_addr) << (PC_W - JMP_W);
  assign full   = (sp == SP_W'(STACK_DEPTH));
  assign empty  = (sp == '0);

  always_comb begin
    tos = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp == SP_W'(i + 1)) tos = stack_mem[i];
    end
  end

  // Priority chain; a call or ret only touches the stack when it is the winning control.
  always_comb begin
    pm_next = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.sync_reset) begin
      pm_next = '0;
    end else if (bus.hold) begin
      pm_next = pc;
    end else if (bus.jmp) begin
      pm_next = target;
    end else if (bus.call) begin
      pm_next = target;
      if (full) ovf_set = 1'b1;
      else      push    = 1'b1;
    end else if (bus.ret) begin
      if (!empty) begin
        pm_next = tos;
        pop     = 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end else if (bus.jmp_nz && !bus.dont_jmp) begin
      pm_next = target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc  <= '0;
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
    end else begin
      pc <= pm_next;
      if (bus.sync_reset) begin
        sp  <= '0;
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (push && sp == SP_W'(i)) stack_mem[i] <= pc_inc;
        end
        if (push) sp <= sp + SP_W'(1);
        if (pop)  sp <= sp - SP_W'(1);
        if (ovf_set) ovf <= 1'b1;
        if (unf_set) unf <= 1'b1;
      end
    end
  end

  assign bus.pm_addr         = reset_n ? pm_next : '0;
  assign bus.pc              = pc;
  assign bus.sp              = sp;
  assign bus.stack_full      = full;
  assign bus.stack_empty     = empty;
  assign bus.stack_overflow  = ovf;
  assign bus.stack_underflow = unf;
endmodule
